hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the MIPS pipeline. Holds an in-flight record (dest reg, Tnew, EPC-write flag) for every stage after D.
- Ages each Tnew by one per pipeline advance.
- Compares records against the D-stage sources and Tuse to generate the D-stage stall, D-stage forward selects and the eret/EPC interlock.
- Replaces the per-stage combinational Tnew decoders. Sits beside the D/E pipeline register, driven by the decoder.

Parameters:
- DEPTH, 3, number of tracked stages after D (1=E, 2=M, 3=W, ...).
- TW, 2, width of Tnew/Tuse fields.
- SELW, 2, width of forward-select outputs; must satisfy 2^SELW > DEPTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all records
- flush  in  1  exception/interrupt flush; clears all records on the next edge
- d_rs  in  5  D-stage rs address
- d_rt  in  5  D-stage rt address
- d_tuse_rs  in  TW  cycles until rs is needed (all-ones = not used)
- d_tuse_rt  in  TW  same, for rt
- d_dst  in  5  destination of the D instruction (0 = no write)
- d_tnew  in  TW  Tnew of the D instruction as it enters E
- d_epc_wr  in  1  D instruction is mtc0 to CP0 reg 14
- d_eret  in  1  D instruction is eret
- stall  out  1  freeze PC/F/D, inject bubble into E
- fwd_rs_sel  out  SELW  0 = register file, k = forward from stage k
- fwd_rt_sel  out  SELW  same, for rt
- epc_pending  out  1  some valid record writes EPC

Behaviour:
- Record k (1..DEPTH) fields: valid, dst[4:0], tnew[TW-1:0], epc.
- Reset and flush are synchronous and take priority (reset > flush). All records invalid, tnew=0.
- Outputs after reset: stall=0, fwd_*_sel=0, epc_pending=0.
- Every non-reset, non-flush edge, regardless of stall:
  - record k+1 <= record k, with tnew saturating-decremented (0 stays 0);
  - record DEPTH is discarded.
- Record 1 loading:
  - stall=0: load {d_dst!=0 || d_epc_wr, d_dst, d_tnew, d_epc_wr}.
  - stall=1: record 1 becomes a bubble (valid=0).
- Matching: record k matches rs if valid && dst!=0 && dst==d_rs. Same for rt. Register 0 never matches.
- Youngest matching record (lowest k) decides; older matches are ignored.
  - stall_rs = youngest match has tnew > d_tuse_rs. Same for rt.
  - fwd_rs_sel = k if the youngest match has tnew==0, else 0.
- stall_eret = d_eret && epc_pending.
- epc_pending = OR over records of (valid && epc).
- stall = stall_rs | stall_rt | stall_eret (| MDU term when enabled). All outputs are combinational from current records and D inputs.
- d_tuse all-ones: a match can never stall, because TW saturates below it with Tnew ≤ 2^TW-2. Decoders must keep Tnew ≤ 2^TW-2.
- Simultaneous flush and stall: flush wins. Records are cleared, no bubble bookkeeping.
- Reset mid-stall: records cleared and stall drops on the next cycle.

Optional Feature:
- Macro HAZ_MDU_EN.
- Enabled adds these ports:
  - d_md  in  1  D uses the multiply/divide unit
  - e_md_start  in  1  E holds mult/div start
  - mdu_busy  in  1  MDU busy
- Stall term: d_md && (mdu_busy || e_md_start).
- Disabled: ports are absent and there is no MDU term.

Decomposition:
- Shared package/define file: TW/SELW defaults, TUSE_NONE (all-ones), FWD_RF=0, CP0 EPC index 14.
- One sub-module, hz_slot: a single record register with load/bubble/clear and saturating decrement.
- The top instantiates DEPTH slots with a generate loop, plus a youngest-match priority encoder.

Test Plan:
1. lw $8 (d_tnew=2) then addu using rs=$8, tuse=0 -> stall=1 for 2 cycles, then fwd_rs_sel=3 (W) with stall=0.
2. addu $9 (tnew=1) then beq rs=$9, tuse=0 -> one stall cycle, then fwd_rs_sel=2 (M).
3. Two writers to $10 in E (tnew=0) and M (tnew=0), reader rt=$10 -> fwd_rt_sel=1 (youngest), stall=0.
4. Reader of $0 behind an older lw whose d_dst is $0 -> d_dst==0 gives that record valid=0, so there is no match: stall=0, fwd_rs_sel=0.
5. mtc0 EPC then eret -> epc_pending=1 and stall=1 for DEPTH cycles until the record exits, then stall=0.
6. lw $8 then a stalled reader; assert flush during the stall -> all records cleared next cycle, stall=0, epc_pending=0. Also verify that reset asserted mid-stall gives the same result.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_scoreboard_pkg                                           |
// | Brief  : Shared defaults and constants for the hazard scoreboard.        |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package hazard_scoreboard_pkg;

    localparam int c_DEPTH_DEF = 3;
    localparam int c_TW_DEF    = 2;
    localparam int c_SELW_DEF  = 2;
    localparam int c_REG_W     = 5;

    // Forward select value meaning "take the register file value".
    localparam int c_FWD_RF    = 0;
    // CP0 register index of EPC (target of the tracked mtc0).
    localparam int c_CP0_EPC   = 14;

    typedef logic [c_REG_W-1:0] reg_addr_t;

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_slot.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hz_slot                                                         |
// | Brief  : One in-flight record: load / bubble / clear, sat. Tnew ageing.  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module hz_slot
    import hazard_scoreboard_pkg::*;
#(
    parameter int TW = c_TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_bubble,
    input  logic          i_dec,
    input  logic          i_valid,
    input  reg_addr_t     i_dst,
    input  logic [TW-1:0] i_tnew,
    input  logic          i_epc,
    output logic          o_valid,
    output reg_addr_t     o_dst,
    output logic [TW-1:0] o_tnew,
    output logic          o_epc
);

    logic [TW-1:0] w_tnew_next;

    // Saturating decrement: a result already available stays available.
    always_comb begin
        w_tnew_next = i_tnew;
        if (i_dec && (i_tnew != '0)) begin
            w_tnew_next = i_tnew - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear || i_bubble) begin
            o_valid <= 1'b0;
            o_dst   <= '0;
            o_tnew  <= '0;
            o_epc   <= 1'b0;
        end else begin
            o_valid <= i_valid;
            o_dst   <= i_dst;
            o_tnew  <= w_tnew_next;
            o_epc   <= i_epc;
        end
    end

endmodule : hz_slot
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hazard_scoreboard                                               |
// | Brief  : Tnew/Tuse hazard unit: D-stage stall, forward selects, eret/EPC |
// |          interlock. Optional MDU interlock under macro HAZ_MDU_EN.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = c_DEPTH_DEF,
    parameter int TW    = c_TW_DEF,
    parameter int SELW  = c_SELW_DEF    // 2**SELW must exceed DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic [4:0]      d_rs,
    input  logic [4:0]      d_rt,
    input  logic [TW-1:0]   d_tuse_rs,
    input  logic [TW-1:0]   d_tuse_rt,
    input  logic [4:0]      d_dst,
    input  logic [TW-1:0]   d_tnew,
    input  logic            d_epc_wr,
    input  logic            d_eret,
`ifdef HAZ_MDU_EN
    input  logic            d_md,
    input  logic            e_md_start,
    input  logic            mdu_busy,
`endif
    output logic            stall,
    output logic [SELW-1:0] fwd_rs_sel,
    output logic [SELW-1:0] fwd_rt_sel,
    output logic            epc_pending
);

    // Index 0 is the D-stage candidate; index k is record k.
    logic          w_valid [0:DEPTH];
    reg_addr_t     w_dst   [0:DEPTH];
    logic [TW-1:0] w_tnew  [0:DEPTH];
    logic          w_epc   [0:DEPTH];

    logic          w_stall;
    logic          w_stall_rs;
    logic          w_stall_rt;
    logic          w_stall_eret;
    logic          w_stall_mdu;
    logic          w_epc_pending;

    assign w_valid[0] = (d_dst != '0) || d_epc_wr;
    assign w_dst[0]   = d_dst;
    assign w_tnew[0]  = d_tnew;
    assign w_epc[0]   = d_epc_wr;

    // Record 1 takes Tnew as-is; older records age by one per edge.
    for (genvar k = 1; k <= DEPTH; k++) begin : g_slot
        hz_slot #(
            .TW (TW)
        ) u_slot (
            .clk      (clk),
            .rst      (reset),
            .i_clear  (flush),
            .i_bubble ((k == 1) ? w_stall : 1'b0),
            .i_dec    (k != 1),
            .i_valid  (w_valid[k-1]),
            .i_dst    (w_dst[k-1]),
            .i_tnew   (w_tnew[k-1]),
            .i_epc    (w_epc[k-1]),
            .o_valid  (w_valid[k]),
            .o_dst    (w_dst[k]),
            .o_tnew   (w_tnew[k]),
            .o_epc    (w_epc[k])
        );
    end

    // Youngest-match priority encoder: scan oldest to youngest, last hit wins.
    always_comb begin
        w_stall_rs    = 1'b0;
        w_stall_rt    = 1'b0;
        fwd_rs_sel    = SELW'(c_FWD_RF);
        fwd_rt_sel    = SELW'(c_FWD_RF);
        w_epc_pending = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_valid[k] && (w_dst[k] != '0) && (w_dst[k] == d_rs)) begin
                w_stall_rs = (w_tnew[k] > d_tuse_rs);
                fwd_rs_sel = (w_tnew[k] == '0) ? SELW'(k) : SELW'(c_FWD_RF);
            end
            if (w_valid[k] && (w_dst[k] != '0) && (w_dst[k] == d_rt)) begin
                w_stall_rt = (w_tnew[k] > d_tuse_rt);
                fwd_rt_sel = (w_tnew[k] == '0) ? SELW'(k) : SELW'(c_FWD_RF);
            end
            if (w_valid[k] && w_epc[k]) begin
                w_epc_pending = 1'b1;
            end
        end
    end

    assign w_stall_eret = d_eret && w_epc_pending;

`ifdef HAZ_MDU_EN
    assign w_stall_mdu = d_md && (mdu_busy || e_md_start);
`else
    assign w_stall_mdu = 1'b0;
`endif

    assign w_stall     = w_stall_rs || w_stall_rt || w_stall_eret || w_stall_mdu;
    assign stall       = w_stall;
    assign epc_pending = w_epc_pending;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_hazard_scoreboard                                            |
// | Brief  : Directed self-checking bench for hazard_scoreboard (DEPTH=3).   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int         c_TW   = 2;
    localparam int         c_SELW = 2;
    localparam logic [1:0] c_NONE = 2'b11;

    logic       clk = 1'b0;
    logic       reset, flush;
    logic [4:0] d_rs, d_rt, d_dst;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_epc_wr, d_eret;
    logic       stall, epc_pending;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZ_MDU_EN
    logic       d_md = 1'b0, e_md_start = 1'b0, mdu_busy = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .TW(c_TW), .SELW(c_SELW)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_dst       (d_dst),
        .d_tnew      (d_tnew),
        .d_epc_wr    (d_epc_wr),
        .d_eret      (d_eret),
`ifdef HAZ_MDU_EN
        .d_md        (d_md),
        .e_md_start  (e_md_start),
        .mdu_busy    (mdu_busy),
`endif
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .epc_pending (epc_pending)
    );

    // Inputs change 1ns after the edge; outputs are sampled 4ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                         input logic [4:0] rt, input logic [1:0] tu_rt,
                         input logic [4:0] dst, input logic [1:0] tnew,
                         input logic epc, input logic eret);
        d_rs = rs; d_tuse_rs = tu_rs; d_rt = rt; d_tuse_rt = tu_rt;
        d_dst = dst; d_tnew = tnew; d_epc_wr = epc; d_eret = eret;
        #4;
    endtask

    task automatic nop();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0;
        nop();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nop();
        n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else n_pass++;
        n_checks++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0)
            $display("FAIL reset_fwd got %0d/%0d exp 0/0", fwd_rs_sel, fwd_rt_sel); else n_pass++;
        n_checks++; if (epc_pending !== 1'b0) $display("FAIL reset_epc got %b exp 0", epc_pending); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd8, 2'd2, 1'b0, 1'b0);  // lw $8
        n_checks++; if (stall !== 1'b0) $display("FAIL lu_lw_in_d got %b exp 0", stall); else n_pass++;
        tick();
        set_d(5'd8, 2'd0, 5'd0, c_NONE, 5'd11, 2'd1, 1'b0, 1'b0);   // addu rs=$8
        n_checks++; if (stall !== 1'b1 || fwd_rs_sel !== 2'd0)
            $display("FAIL lu_stall1 got %b/%0d exp 1/0", stall, fwd_rs_sel); else n_pass++;
        tick(); #4;
        n_checks++; if (stall !== 1'b1) $display("FAIL lu_stall2 got %b exp 1", stall); else n_pass++;
        tick(); #4;
        n_checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd3)
            $display("FAIL lu_fwd_w got %b/%0d exp 0/3", stall, fwd_rs_sel); else n_pass++;
    endtask

    task automatic test_branch_use();
        do_reset();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd9, 2'd1, 1'b0, 1'b0);  // addu $9
        tick();
        set_d(5'd9, 2'd0, 5'd0, c_NONE, 5'd0, 2'd0, 1'b0, 1'b0);    // beq rs=$9
        n_checks++; if (stall !== 1'b1) $display("FAIL br_stall got %b exp 1", stall); else n_pass++;
        tick(); #4;
        n_checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd2)
            $display("FAIL br_fwd_m got %b/%0d exp 0/2", stall, fwd_rs_sel); else n_pass++;
        // Tnew equal to Tuse never stalls.
        do_reset();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd9, 2'd1, 1'b0, 1'b0);
        tick();
        set_d(5'd0, c_NONE, 5'd9, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0 || fwd_rt_sel !== 2'd0)
            $display("FAIL tuse_eq got %b/%0d exp 0/0", stall, fwd_rt_sel); else n_pass++;
        // rt one cycle short of its Tuse stalls.
        set_d(5'd0, c_NONE, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b1) $display("FAIL rt_stall got %b exp 1", stall); else n_pass++;
    endtask

    task automatic test_youngest();
        do_reset();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd10, 2'd0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd10, 2'd0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, c_NONE, 5'd10, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0 || fwd_rt_sel !== 2'd1 || fwd_rs_sel !== 2'd0)
            $display("FAIL youngest got %b/%0d/%0d exp 0/1/0", stall, fwd_rt_sel, fwd_rs_sel); else n_pass++;
    endtask

    task automatic test_reg_zero_and_none();
        do_reset();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd0, 2'd2, 1'b0, 1'b0);  // lw $0
        tick();
        set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || epc_pending !== 1'b0)
            $display("FAIL reg0 got %b/%0d/%b exp 0/0/0", stall, fwd_rs_sel, epc_pending); else n_pass++;
        do_reset();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd8, 2'd2, 1'b0, 1'b0);
        tick();
        set_d(5'd8, c_NONE, 5'd0, c_NONE, 5'd0, 2'd0, 1'b0, 1'b0);  // rs matched but unused
        n_checks++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0)
            $display("FAIL tuse_none got %b/%0d exp 0/0", stall, fwd_rs_sel); else n_pass++;
    endtask

    task automatic test_eret();
        do_reset();
        set_d(5'd0, c_NONE, 5'(c_CP0_EPC), c_NONE, 5'd0, 2'd0, 1'b1, 1'b0);  // mtc0 EPC
        tick();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd0, 2'd0, 1'b0, 1'b1);  // eret
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (stall !== 1'b1 || epc_pending !== 1'b1)
                $display("FAIL eret_hold%0d got %b/%b exp 1/1", i, stall, epc_pending); else n_pass++;
            tick(); #4;
        end
        n_checks++; if (stall !== 1'b0 || epc_pending !== 1'b0)
            $display("FAIL eret_release got %b/%b exp 0/0", stall, epc_pending); else n_pass++;
    endtask

    task automatic test_flush_reset(input bit use_reset);
        do_reset();
        set_d(5'd0, c_NONE, 5'(c_CP0_EPC), c_NONE, 5'd0, 2'd0, 1'b1, 1'b0);
        tick();
        set_d(5'd0, c_NONE, 5'd0, c_NONE, 5'd8, 2'd2, 1'b0, 1'b0);
        tick();
        set_d(5'd8, 2'd0, 5'd0, c_NONE, 5'd0, 2'd0, 1'b0, 1'b0);
        n_checks++; if (stall !== 1'b1 || epc_pending !== 1'b1)
            $display("FAIL pre_clear%0d got %b/%b exp 1/1", use_reset, stall, epc_pending); else n_pass++;
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        tick();
        reset = 1'b0; flush = 1'b0;
        #4;
        n_checks++; if (stall !== 1'b0 || epc_pending !== 1'b0 || fwd_rs_sel !== 2'd0)
            $display("FAIL post_clear%0d got %b/%b/%0d exp 0/0/0", use_reset, stall, epc_pending, fwd_rs_sel);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        nop();
        test_reset();
        test_load_use();
        test_branch_use();
        test_youngest();
        test_reg_zero_and_none();
        test_eret();
        test_flush_reset(1'b0);
        test_flush_reset(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hazard_scoreboard
`default_nettype wire
